counter_updown_mod: RTL and testbench

Parametrised modulo-N up/down counter: the next generation of our 4-bit free-running binary counter. It adds configurable width and modulus, direction control, enable, synchronous clear and load, an enable prescaler, and wrap or saturate terminal behaviour with status flags. It is intended as the general-purpose counting primitive for timers, dividers and sequencers in later exercises.

---
 rtl/counter_updown_mod_pkg.sv | 22 ++
 rtl/counter_updown_mod_prescaler.sv | 48 ++++
 rtl/counter_updown_mod.sv | 122 ++++++++++++
 tb/tb_counter_updown_mod.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_updown_mod_pkg.sv
// counter_updown_mod_pkg
// Shared definitions for the up/down counter slice.
//   MODE_WRAP / MODE_SAT : terminal behaviour selectors for the SATURATE parameter
//   modulusLegal()       : true when 2 <= modulus <= 2**width
//   prescaleWidth()      : width of the prescaler phase counter (never below 1)
package counter_updown_mod_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Evaluated at 64 bits so that WIDTH values up to 31 still compare correctly.
  function automatic bit modulusLegal(input int width, input int modulus);
    longint limit;
    limit = longint'(1) << width;
    return (modulus >= 2) && (longint'(modulus) <= limit);
  endfunction

  function automatic int prescaleWidth(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/counter_updown_mod_prescaler.sv
// prescaler_tick
// Divides the count enable so that one tick is issued every PRESCALE enabled
// cycles. The phase only advances while en is high and is held otherwise.
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   en       in  enable; advances the phase
//   sync_clr in  synchronous return of the phase to zero
//   tick     out high in the enabled cycle that completes a PRESCALE period
module prescaler_tick
  import counter_updown_mod_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int CW = prescaleWidth(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] phase_q, phase_d;

  // With PRESCALE=1 the phase is pinned at zero, so tick degenerates to en.
  assign tick = en && (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (sync_clr) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod
// Modulo-MODULUS up/down counter with prescaled enable, synchronous clear and
// load, and either wrap-around or saturation at the range limits.
//   clk, rst_n         clock and asynchronous active-low reset
//   en, up             count enable and direction (1 = up)
//   clr, load          synchronous clear / load (clr has priority)
//   load_val           value loaded, clamped to MODULUS-1
//   count              registered count value
//   at_max, at_min     count == MODULUS-1 / count == 0
//   wrap               one-cycle pulse after a wrap step (wrap mode only)
//   sat                sticky flag: a step was blocked at a limit
module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat
);

  // Reject illegal parameter combinations while elaborating.
  if (!modulusLegal(WIDTH, MODULUS)) begin : gBadModulus
    $error("counter_updown_mod: MODULUS=%0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
  end
  if (PRESCALE < 1) begin : gBadPrescale
    $error("counter_updown_mod: PRESCALE=%0d must be at least 1", PRESCALE);
  end

  // Limit held one bit wider so MODULUS = 2**WIDTH still yields a valid maximum.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             tick;
  logic [WIDTH:0]   countExt;
  logic [WIDTH:0]   loadExt;

  // clr and load both restart the prescaler phase.
  prescaler_tick #(
    .PRESCALE (PRESCALE)
  ) uPrescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (clr | load),
    .tick     (tick)
  );

  assign countExt = {1'b0, count_q};
  assign loadExt  = {1'b0, load_val};

  // Next-state: clr > load > step > hold. wrap defaults low so it only pulses.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (load) begin
      count_d = (loadExt > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;
      sat_d   = 1'b0;
    end else if (tick) begin
      if (up) begin
        if (countExt == MAX_EXT) begin
          if (SATURATE == MODE_SAT) begin
            sat_d = 1'b1;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = WIDTH'(countExt + 1'b1);
        end
      end else begin
        if (countExt == '0) begin
          if (SATURATE == MODE_SAT) begin
            sat_d = 1'b1;
          end else begin
            count_d = MAX_EXT[WIDTH-1:0];
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = WIDTH'(countExt - 1'b1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign sat    = sat_q;
  assign at_max = (countExt == MAX_EXT);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod
// Drives four differently parameterised counters with shared stimulus and
// compares every output against a plain-arithmetic reference on each cycle.
//   inst 0: MODULUS=16 PRESCALE=1 wrap
//   inst 1: MODULUS=10 PRESCALE=1 wrap
//   inst 2: MODULUS=16 PRESCALE=1 saturate
//   inst 3: MODULUS=10 PRESCALE=3 wrap
module tb_counter_updown_mod;

  localparam int N = 4;
  localparam int MODS [N] = '{16, 10, 16, 10};
  localparam int PRES [N] = '{1, 1, 1, 3};
  localparam int SATS [N] = '{0, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] loadVal = '0;

  logic [3:0] dCount [N];
  logic       dMax [N];
  logic       dMin [N];
  logic       dWrap [N];
  logic       dSat [N];

  int mCount [N];
  int mPre [N];
  bit mWrap [N];
  bit mSat [N];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gDut
    counter_updown_mod #(
      .WIDTH    (4),
      .MODULUS  (MODS[g]),
      .PRESCALE (PRES[g]),
      .SATURATE (SATS[g])
    ) dut (
      .clk      (clk),
      .rst_n    (rstN),
      .en       (en),
      .up       (up),
      .clr      (clr),
      .load     (load),
      .load_val (loadVal),
      .count    (dCount[g]),
      .at_max   (dMax[g]),
      .at_min   (dMin[g]),
      .wrap     (dWrap[g]),
      .sat      (dSat[g])
    );
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end else begin
      passed++;
    end
  endtask

  // Reference: count as a signed integer, step by +/-1, then fold back into
  // range either modulo MODULUS or by refusing the step.
  always @(posedge clk or negedge rstN) begin
    for (int i = 0; i < N; i++) begin
      if (!rstN) begin
        mCount[i] = 0; mPre[i] = 0; mWrap[i] = 0; mSat[i] = 0;
      end else if (clr) begin
        mCount[i] = 0; mPre[i] = 0; mWrap[i] = 0; mSat[i] = 0;
      end else if (load) begin
        mCount[i] = (int'(loadVal) > MODS[i] - 1) ? MODS[i] - 1 : int'(loadVal);
        mPre[i] = 0; mWrap[i] = 0; mSat[i] = 0;
      end else begin
        mWrap[i] = 0;
        if (en) begin
          mPre[i]++;
          if (mPre[i] == PRES[i]) begin
            int nxt;
            mPre[i] = 0;
            nxt = mCount[i] + (up ? 1 : -1);
            if (nxt < 0 || nxt >= MODS[i]) begin
              if (SATS[i] != 0) mSat[i] = 1;
              else begin
                mCount[i] = (nxt + MODS[i]) % MODS[i];
                mWrap[i] = 1;
              end
            end else begin
              mCount[i] = nxt;
            end
          end
        end
      end
    end
  end

  // Every falling edge: all outputs of all instances against the reference.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("count[%0d]", i), int'(dCount[i]), mCount[i]);
      checkOutput($sformatf("at_max[%0d]", i), int'(dMax[i]), int'(mCount[i] == MODS[i] - 1));
      checkOutput($sformatf("at_min[%0d]", i), int'(dMin[i]), int'(mCount[i] == 0));
      checkOutput($sformatf("wrap[%0d]", i), int'(dWrap[i]), int'(mWrap[i]));
      checkOutput($sformatf("sat[%0d]", i), int'(dSat[i]), int'(mSat[i]));
    end
  end

  // Drive one cycle of inputs from a falling edge and return at the next one.
  task automatic applyStimulus(input logic e, input logic u, input logic c,
                               input logic l, input logic [3:0] v);
    en = e; up = u; clr = c; load = l; loadVal = v;
    @(negedge clk);
  endtask

  initial begin
    #1 rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset count A", int'(dCount[0]), 0);
    checkOutput("reset at_min A", int'(dMin[0]), 1);
    checkOutput("reset at_max A", int'(dMax[0]), 0);
    rstN = 1'b1;

    // Up-count from reset through the top of the range.
    for (int k = 0; k < 15; k++) applyStimulus(1, 1, 0, 0, 4'd0);
    checkOutput("up15 count A", int'(dCount[0]), 15);
    checkOutput("up15 at_max A", int'(dMax[0]), 1);
    checkOutput("up15 model A", mCount[0], 15);
    applyStimulus(1, 1, 0, 0, 4'd0);
    checkOutput("up16 wrap count A", int'(dCount[0]), 0);
    checkOutput("up16 wrap A", int'(dWrap[0]), 1);
    checkOutput("up16 count B", int'(dCount[1]), 6);
    checkOutput("up16 hold C", int'(dCount[2]), 15);
    checkOutput("up16 sat C", int'(dSat[2]), 1);
    checkOutput("up16 prescaled D", int'(dCount[3]), 5);
    checkOutput("up16 model D", mCount[3], 5);

    // Clear removes the sticky flag, then one down step from zero.
    applyStimulus(1, 1, 1, 0, 4'd0);
    checkOutput("clr count C", int'(dCount[2]), 0);
    checkOutput("clr sat C", int'(dSat[2]), 0);
    applyStimulus(1, 0, 0, 0, 4'd0);
    checkOutput("down wrap count B", int'(dCount[1]), 9);
    checkOutput("down wrap B", int'(dWrap[1]), 1);
    checkOutput("down hold C", int'(dCount[2]), 0);
    checkOutput("down sat C", int'(dSat[2]), 1);
    checkOutput("down first enable D", int'(dCount[3]), 0);

    // Load beats stepping, clamps to the range, and loses to clear.
    applyStimulus(1, 1, 0, 1, 4'd7);
    checkOutput("load7 A", int'(dCount[0]), 7);
    checkOutput("load7 sat C", int'(dSat[2]), 0);
    applyStimulus(1, 1, 0, 1, 4'd12);
    checkOutput("load12 A", int'(dCount[0]), 12);
    checkOutput("load12 clamp B", int'(dCount[1]), 9);
    applyStimulus(1, 1, 1, 1, 4'd12);
    checkOutput("clr+load A", int'(dCount[0]), 0);

    // Prescaler phase: nine enabled cycles give three steps; a two-cycle
    // enable gap delays the following step by exactly two cycles.
    for (int k = 0; k < 9; k++) applyStimulus(1, 1, 0, 0, 4'd0);
    checkOutput("pre9 D", int'(dCount[3]), 3);
    applyStimulus(0, 1, 1, 0, 4'd0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0, 0, 4'd0);
    checkOutput("pre4 D", int'(dCount[3]), 1);
    applyStimulus(0, 1, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);
    applyStimulus(1, 1, 0, 0, 4'd0);
    checkOutput("pre gap D", int'(dCount[3]), 1);
    applyStimulus(1, 1, 0, 0, 4'd0);
    checkOutput("pre resume D", int'(dCount[3]), 2);

    // Asynchronous reset between edges, then restart.
    applyStimulus(1, 1, 1, 0, 4'd0);
    for (int k = 0; k < 5; k++) applyStimulus(1, 1, 0, 0, 4'd0);
    checkOutput("pre-reset A", int'(dCount[0]), 5);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async count A", int'(dCount[0]), 0);
    checkOutput("async at_min A", int'(dMin[0]), 1);
    checkOutput("async sat C", int'(dSat[2]), 0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1, 1, 0, 0, 4'd0);
    checkOutput("restart A", int'(dCount[0]), 1);

    // Randomised traffic with occasional mid-cycle resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        #2 rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
      end else begin
        applyStimulus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                      logic'($urandom_range(0, 32) == 0), logic'($urandom_range(0, 19) == 0),
                      4'($urandom_range(0, 15)));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
